// File: rtl/consec_seq_gen.sv
// Stimulus generator for "a |=> b[*N]": pulses a, holds b for N cycles, then pulses done.
// Optional macro FAULT_INJECT_EN adds fault_en/fault_at to drop b in one HOLD cycle.
module consec_seq_gen #(
    parameter int REP_W   = 4,
    parameter int DEF_REP = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             start_def,
    input  logic [REP_W-1:0] rep_cnt,
`ifdef FAULT_INJECT_EN
    input  logic             fault_en,
    input  logic [REP_W-1:0] fault_at,
`endif
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TRIG = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [REP_W-1:0] DEF_N = REP_W'(DEF_REP);

    state_t           state_q, state_d;
    logic [REP_W-1:0] n_q, n_d;
    logic [REP_W-1:0] cnt_q, cnt_d;
    logic             a_q, a_d;
    logic             b_q, b_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             drop_first;
    logic             drop_next;

`ifdef FAULT_INJECT_EN
    logic             fen_q, fen_d;
    logic [REP_W-1:0] fat_q, fat_d;

    // b is dropped when the upcoming HOLD index matches the latched fault index
    always_comb begin
        drop_first = fen_q && (fat_q == '0);
        drop_next  = fen_q && (fat_q == (n_q - cnt_q));
    end
`else
    // b is never dropped inside HOLD
    always_comb begin
        drop_first = 1'b0;
        drop_next  = 1'b0;
    end
`endif

    // next-state and next-output decode; outputs describe the cycle after the edge
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        a_d     = 1'b0;
        b_d     = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
`ifdef FAULT_INJECT_EN
        fen_d   = fen_q;
        fat_d   = fat_q;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = TRIG;
                    n_d     = start_def ? DEF_N : rep_cnt;
                    a_d     = 1'b1;
                    busy_d  = 1'b1;
`ifdef FAULT_INJECT_EN
                    fen_d   = fault_en;
                    fat_d   = fault_at;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            TRIG: begin
                if (n_q != '0) begin
                    state_d = HOLD;
                    cnt_d   = n_q - 1'b1;
                    b_d     = !drop_first;
                    busy_d  = 1'b1;
                end else begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d  = cnt_q - 1'b1;
                    b_d    = !drop_next;
                    busy_d = 1'b1;
                end
            end
        endcase
    end

    // state, counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            n_q     <= '0;
            cnt_q   <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef FAULT_INJECT_EN
            fen_q   <= 1'b0;
            fat_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef FAULT_INJECT_EN
            fen_q   <= fen_d;
            fat_q   <= fat_d;
`endif
        end
    end

    assign a    = a_q;
    assign b    = b_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_consec_seq_gen.sv
// Scoreboard bench for consec_seq_gen: expected {a,b,busy,done} per cycle queued at start.
// Fault-injection scenario is included when FAULT_INJECT_EN is defined.
module tb_consec_seq_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       start_def = 1'b0;
    logic [3:0] rep_cnt = '0;
`ifdef FAULT_INJECT_EN
    logic       fault_en = 1'b0;
    logic [3:0] fault_at = '0;
`endif
    logic       a, b, busy, done;

    consec_seq_gen #(.REP_W(4), .DEF_REP(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .start_def (start_def),
        .rep_cnt   (rep_cnt),
`ifdef FAULT_INJECT_EN
        .fault_en  (fault_en),
        .fault_at  (fault_at),
`endif
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] V_A = 4'b1010;
    localparam logic [3:0] V_B = 4'b0110;
    localparam logic [3:0] V_G = 4'b0010;
    localparam logic [3:0] V_D = 4'b0001;
    localparam logic [3:0] V_I = 4'b0000;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [3:0] sbq[$];

    task automatic push_seq(input int n, input int fidx);
        sbq.push_back(V_A);
        for (int i = 0; i < n; i++)
            sbq.push_back((i == fidx) ? V_G : V_B);
        sbq.push_back(V_D);
    endtask

    task automatic start_req(input logic [3:0] n, input logic d);
        @(negedge clk);
        start     = 1'b1;
        rep_cnt   = n;
        start_def = d;
    endtask

    task automatic test_reset();
        logic [3:0] obs;
        start   = 1'b1;
        rep_cnt = 4'd2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            obs = {a, b, busy, done};
            n_checks++;
            if (obs !== V_I) begin
                n_fail++;
                $display("FAIL reset_hold cyc %0d: got %b want %b", i, obs, V_I);
            end
        end
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        obs = {a, b, busy, done};
        n_checks++;
        if (obs !== V_I) begin
            n_fail++;
            $display("FAIL reset_release: got %b want %b", obs, V_I);
        end
    endtask

    task automatic test_single(input string name, input logic [3:0] n);
        logic [3:0] obs, e;
        int i;
        start_req(n, 1'b0);
        push_seq(int'(n), -1);
        sbq.push_back(V_I);
        i = 0;
        while (sbq.size() > 0) begin
            @(negedge clk);
            start = 1'b0;
            e = sbq.pop_front();
            obs = {a, b, busy, done};
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL %s cyc %0d: got %b want %b", name, i, obs, e);
            end
            i++;
        end
    endtask

    task automatic test_def_ignore();
        logic [3:0] obs, e;
        int i;
        start_req(4'd7, 1'b1);
        push_seq(3, -1);
        sbq.push_back(V_I);
        i = 0;
        while (sbq.size() > 0) begin
            @(negedge clk);
            start = (i == 2);
            if (i == 2) begin
                rep_cnt   = 4'd9;
                start_def = 1'b0;
            end
            e = sbq.pop_front();
            obs = {a, b, busy, done};
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL def_ignore cyc %0d: got %b want %b", i, obs, e);
            end
            i++;
        end
        start_def = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [3:0] obs, e;
        int i;
        start_req(4'd2, 1'b0);
        push_seq(2, -1);
        push_seq(2, -1);
        sbq.push_back(V_I);
        i = 0;
        while (sbq.size() > 0) begin
            @(negedge clk);
            if (i == 7)
                start = 1'b0;
            e = sbq.pop_front();
            obs = {a, b, busy, done};
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL back_to_back cyc %0d: got %b want %b", i, obs, e);
            end
            i++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [3:0] obs, e;
        int i;
        start_req(4'd5, 1'b0);
        sbq.push_back(V_A);
        sbq.push_back(V_B);
        sbq.push_back(V_B);
        i = 0;
        while (sbq.size() > 0) begin
            @(negedge clk);
            start = 1'b0;
            e = sbq.pop_front();
            obs = {a, b, busy, done};
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL reset_mid_pre cyc %0d: got %b want %b", i, obs, e);
            end
            i++;
        end
        rst_n = 1'b0;
        #1;
        obs = {a, b, busy, done};
        n_checks++;
        if (obs !== V_I) begin
            n_fail++;
            $display("FAIL reset_mid_drop: got %b want %b", obs, V_I);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            obs = {a, b, busy, done};
            n_checks++;
            if (obs !== V_I) begin
                n_fail++;
                $display("FAIL reset_mid_nodone cyc %0d: got %b want %b", k, obs, V_I);
            end
        end
        rst_n = 1'b1;
        start_req(4'd5, 1'b0);
        push_seq(5, -1);
        sbq.push_back(V_I);
        i = 0;
        while (sbq.size() > 0) begin
            @(negedge clk);
            start = 1'b0;
            e = sbq.pop_front();
            obs = {a, b, busy, done};
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL reset_mid_post cyc %0d: got %b want %b", i, obs, e);
            end
            i++;
        end
    endtask

`ifdef FAULT_INJECT_EN
    task automatic test_fault(input logic [3:0] fat, input int fidx);
        logic [3:0] obs, e;
        int i;
        start_req(4'd3, 1'b0);
        fault_en = 1'b1;
        fault_at = fat;
        push_seq(3, fidx);
        sbq.push_back(V_I);
        i = 0;
        while (sbq.size() > 0) begin
            @(negedge clk);
            start    = 1'b0;
            fault_en = 1'b0;
            e = sbq.pop_front();
            obs = {a, b, busy, done};
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL fault_at%0d cyc %0d: got %b want %b", fat, i, obs, e);
            end
            i++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single("rep3", 4'd3);
        test_single("rep0", 4'd0);
        test_single("rep1", 4'd1);
        test_def_ignore();
        test_back_to_back();
        test_reset_mid();
        test_single("rep15", 4'd15);
`ifdef FAULT_INJECT_EN
        test_fault(4'd1, 1);
        test_fault(4'd5, -1);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
